// File: rtl/sign_extender.sv
// rtl/sign_extender.sv - decode-stage immediate generator with registered outputs
//
// Purpose:
//   Identifies the instruction format from the opcode field, extracts that
//   format's immediate and presents it sign- or zero-extended to WORD bits.
//   Decode is purely combinational; both results are registered, so the
//   outputs follow the instruction by exactly one rising edge.
//
// Ports:
//   clk                  in   1          system clock, rising edge
//   rst                  in   1          synchronous reset, active-high
//   instruction          in   INSTR_LEN  instruction word to decode
//   sign_extended_output out  WORD       format-dependent sign/zero-extended immediate
//   val                  out  WORD       raw immediate field, always zero-extended

module sign_extender #(
  parameter int WORD      = 64,
  parameter int INSTR_LEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INSTR_LEN-1:0] instruction,
  output logic [WORD-1:0]      sign_extended_output,
  output logic [WORD-1:0]      val
);

  logic [WORD-1:0] se_d, se_q;
  logic [WORD-1:0] val_d, val_q;

  // Opcode slices of different lengths; formats are distinguished by how
  // many leading bits they reserve.
  logic [5:0]  op6;
  logic [7:0]  op8;
  logic [8:0]  op9;
  logic [9:0]  op10;
  logic [10:0] op11;

  // Candidate immediate fields
  logic [25:0] imm26;
  logic [18:0] imm19;
  logic [8:0]  imm9;
  logic [11:0] imm12;
  logic [15:0] imm16;
  logic [5:0]  shamt;

  // The destination register field never contributes to an immediate.
  logic unused_rd;

  assign op6   = instruction[31:26];
  assign op8   = instruction[31:24];
  assign op9   = instruction[31:23];
  assign op10  = instruction[31:22];
  assign op11  = instruction[31:21];

  assign imm26 = instruction[25:0];
  assign imm19 = instruction[23:5];
  assign imm9  = instruction[20:12];
  assign imm12 = instruction[21:10];
  assign imm16 = instruction[20:5];
  assign shamt = instruction[15:10];

  assign unused_rd = ^instruction[4:0];

  // Priority decode: the first matching format wins.
  always_comb begin
    se_d  = '0;
    val_d = '0;
    if (op6 == 6'b000101 || op6 == 6'b100101) begin
      // B / BL
      se_d  = {{(WORD-26){imm26[25]}}, imm26};
      val_d = {{(WORD-26){1'b0}}, imm26};
    end else if (op8 == 8'b10110100 || op8 == 8'b10110101 || op8 == 8'b01010100) begin
      // CBZ / CBNZ / B.cond
      se_d  = {{(WORD-19){imm19[18]}}, imm19};
      val_d = {{(WORD-19){1'b0}}, imm19};
    end else if (op11 == 11'b11111000010 || op11 == 11'b11111000000) begin
      // LDUR / STUR
      se_d  = {{(WORD-9){imm9[8]}}, imm9};
      val_d = {{(WORD-9){1'b0}}, imm9};
    end else if (op10 == 10'b1001000100 || op10 == 10'b1011000100 ||
                 op10 == 10'b1101000100 || op10 == 10'b1111000100 ||
                 op10 == 10'b1001001000 || op10 == 10'b1111001000 ||
                 op10 == 10'b1011001000 || op10 == 10'b1101001000) begin
      // Arithmetic/logical immediates are unsigned.
      se_d  = {{(WORD-12){1'b0}}, imm12};
      val_d = {{(WORD-12){1'b0}}, imm12};
    end else if (op9 == 9'b110100101 || op9 == 9'b111100101) begin
      // MOVZ / MOVK
      se_d  = {{(WORD-16){1'b0}}, imm16};
      val_d = {{(WORD-16){1'b0}}, imm16};
    end else if (op11 == 11'b11010011011 || op11 == 11'b11010011010) begin
      // LSL / LSR
      se_d  = {{(WORD-6){1'b0}}, shamt};
      val_d = {{(WORD-6){1'b0}}, shamt};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      se_q  <= '0;
      val_q <= '0;
    end else begin
      se_q  <= se_d;
      val_q <= val_d;
    end
  end

  assign sign_extended_output = se_q;
  assign val                  = val_q;

endmodule

// File: tb/tb_sign_extender.sv
// tb/tb_sign_extender.sv - self-checking bench for sign_extender

module tb_sign_extender;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic [63:0] sign_extended_output;
  logic [63:0] val;

  int total;
  int bad;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [63:0] exp_se;
    logic [63:0] exp_val;
  } vec_t;

  vec_t vecs[$];

  sign_extender #(.WORD(64), .INSTR_LEN(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .instruction          (instruction),
    .sign_extended_output (sign_extended_output),
    .val                  (val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] exp_se, input logic [63:0] exp_val);
    total++;
    if (sign_extended_output !== exp_se) begin
      bad++;
      $display("FAIL %s se: got %h want %h", name, sign_extended_output, exp_se);
    end
    total++;
    if (val !== exp_val) begin
      bad++;
      $display("FAIL %s val: got %h want %h", name, val, exp_val);
    end
  endtask

  task automatic add(input string n, input logic [31:0] i, input logic [63:0] s, input logic [63:0] v);
    vec_t e;
    e.name = n; e.instr = i; e.exp_se = s; e.exp_val = v;
    vecs.push_back(e);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    add("ldur_64",     32'hF84402C9, 64'd64,                 64'd64);
    add("stur_96",     32'hF80602CB, 64'd96,                 64'd96);
    add("add",         32'h8B09032A, 64'd0,                  64'd0);
    add("sub",         32'hCB0A028B, 64'd0,                  64'd0);
    add("orr",         32'hAA150149, 64'd0,                  64'd0);
    add("and",         32'h8A0A02C9, 64'd0,                  64'd0);
    add("cbnz_m5",     32'hB5FFFF6B, 64'hFFFF_FFFF_FFFF_FFFB, 64'h7FFFB);
    add("cbz_8",       32'hB4000109, 64'd8,                  64'd8);
    add("b_64",        32'h14000040, 64'd64,                 64'd64);
    add("b_m55",       32'h17FFFFC9, 64'hFFFF_FFFF_FFFF_FFC9, 64'h3FFFFC9);
    add("addi_fff",    32'h913FFC00, 64'd4095,               64'd4095);
    add("movz_8000",   32'hD2900000, 64'h8000,               64'h8000);
    add("lsl_63",      32'hD360FC00, 64'd63,                 64'd63);
    add("lsr_1",       32'hD3400400, 64'd1,                  64'd1);
    add("movk_ffff",   32'hF29FFFE0, 64'hFFFF,               64'hFFFF);
    add("eori_800",    32'hD2200000, 64'h800,                64'h800);
    add("b_all1",      32'h17FFFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3FFFFFF);
    add("bl_minneg",   32'h96000000, 64'hFFFF_FFFF_FE00_0000, 64'h2000000);
    add("bcond_all1",  32'h54FFFFE0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFFF);
    add("cbz_minneg",  32'hB4800000, 64'hFFFF_FFFF_FFFC_0000, 64'h40000);
    add("ldur_all1",   32'hF85FF000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1FF);
    add("ldur_minneg", 32'hF8500000, 64'hFFFF_FFFF_FFFF_FF00, 64'h100);
    add("unknown",     32'hFFFFFFFF, 64'd0,                  64'd0);

    // Reset state
    rst = 1'b1;
    instruction = 32'h17FFFFC9;
    @(posedge clk);
    @(negedge clk);
    check("reset", 64'd0, 64'd0);
    rst = 1'b0;

    // Table: drive at negedge, one posedge, sample at the following negedge
    for (int k = 0; k < vecs.size(); k++) begin
      instruction = vecs[k].instr;
      @(negedge clk);
      check(vecs[k].name, vecs[k].exp_se, vecs[k].exp_val);
    end

    // Reset wins over a valid instruction applied the same edge
    instruction = 32'h14000040;
    @(negedge clk);
    check("pre_rst_b64", 64'd64, 64'd64);
    rst = 1'b1;
    instruction = 32'h17FFFFC9;
    @(negedge clk);
    check("rst_over_b_m55", 64'd0, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_b_m55", 64'hFFFF_FFFF_FFFF_FFC9, 64'h3FFFFC9);

    // Instruction changes between edges must not affect the outputs
    @(posedge clk);
    #2 instruction = 32'hF84402C9;
    #1 check("hold_between_edges", 64'hFFFF_FFFF_FFFF_FFC9, 64'h3FFFFC9);
    @(negedge clk);
    check("hold_at_negedge", 64'hFFFF_FFFF_FFFF_FFC9, 64'h3FFFFC9);
    @(negedge clk);
    check("load_next_edge", 64'd64, 64'd64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
